// File: rtl/i2c_burst_ctrl.sv
// Burst register read/write sequencer sitting in front of a byte-level I2C master.
// Counts I_BUSY pulses to step through bytes; NACK and inactivity timeouts abort the burst.
module i2c_burst_ctrl #(
  parameter int ADDR_I2C_SZ = 7,
  parameter int DATA_I2C_SZ = 8,
  parameter int MAX_BYTES   = 8,
  parameter int LEN_SZ      = 4,
  parameter int TOUT_CYC    = 500_000
) (
  input  logic                               CLK,
  input  logic                               RST_n,
  input  logic                               I_EN,
  input  logic [ADDR_I2C_SZ-1:0]             I_ADDR_I2C,
  input  logic                               I_RW,
  input  logic [DATA_I2C_SZ-1:0]             I_REG_ADDR,
  input  logic [LEN_SZ-1:0]                  I_LEN,
  input  logic [MAX_BYTES*DATA_I2C_SZ-1:0]   I_WDATA,
  input  logic [DATA_I2C_SZ-1:0]             I_DATA_RD_I2C,
  input  logic                               I_BUSY,
  input  logic                               I_ACK_ERR,
  output logic                               O_EN_I2C,
  output logic [ADDR_I2C_SZ-1:0]             O_ADDR_I2C,
  output logic                               O_RW,
  output logic [DATA_I2C_SZ-1:0]             O_DATA_WR_I2C,
  output logic [MAX_BYTES*DATA_I2C_SZ-1:0]   O_RXD_BUFF,
  output logic                               O_BUSY,
  output logic                               O_DONE,
  output logic                               O_ERR,
  output logic [1:0]                         O_ERR_CODE
);

  localparam int CNT_SZ  = LEN_SZ + 1;
  localparam int TOUT_SZ = $clog2(TOUT_CYC + 1);
  localparam int BUF_SZ  = MAX_BYTES * DATA_I2C_SZ;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    ABORT   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   en_q, busy_q, busy_prev_q;
  logic [CNT_SZ-1:0]      len_q, len_d;
  logic [CNT_SZ-1:0]      cnt_rise_q, cnt_rise_d, cnt_fall_q, cnt_fall_d;
  logic [TOUT_SZ-1:0]     tout_q, tout_d;
  logic [BUF_SZ-1:0]      wdata_q, wdata_d, rxd_q, rxd_d;
  logic                   en_i2c_q, en_i2c_d, rw_q, rw_d;
  logic [ADDR_I2C_SZ-1:0] addr_q, addr_d;
  logic [DATA_I2C_SZ-1:0] data_wr_q, data_wr_d;
  logic                   busy_o_q, busy_o_d, done_q, done_d, err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;

  logic                   busy_rise, busy_fall, legal_len, tout_hit;
  logic [DATA_I2C_SZ-1:0] wbyte [MAX_BYTES];

  assign busy_rise = busy_q & ~busy_prev_q;
  assign busy_fall = ~busy_q & busy_prev_q;
  assign legal_len = (I_LEN != '0) && (CNT_SZ'(I_LEN) <= CNT_SZ'(MAX_BYTES));
  assign tout_hit  = (tout_q == TOUT_SZ'(TOUT_CYC - 1)) && !busy_rise && !busy_fall;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_wbyte
      assign wbyte[gi] = wdata_q[gi*DATA_I2C_SZ +: DATA_I2C_SZ];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_rise_d = cnt_rise_q;
    cnt_fall_d = cnt_fall_q;
    tout_d     = tout_q;
    wdata_d    = wdata_q;
    rxd_d      = rxd_q;
    en_i2c_d   = en_i2c_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_wr_d  = data_wr_q;
    busy_o_d   = busy_o_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        tout_d = '0;
        if (en_q) begin
          if (legal_len) begin
            len_d      = CNT_SZ'(I_LEN);
            wdata_d    = I_WDATA;
            cnt_rise_d = '0;
            cnt_fall_d = '0;
            err_d      = 1'b0;
            err_code_d = 2'b00;
            busy_o_d   = 1'b1;
            en_i2c_d   = 1'b1;
            addr_d     = I_ADDR_I2C;
            rw_d       = 1'b0;
            data_wr_d  = I_REG_ADDR;
            state_d    = I_RW ? RD_ADDR : WR_DATA;
            if (I_RW) begin
              for (int k = 0; k < MAX_BYTES; k++) begin
                if (CNT_SZ'(k) >= CNT_SZ'(I_LEN)) rxd_d[k*DATA_I2C_SZ +: DATA_I2C_SZ] = '0;
              end
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
            done_d     = 1'b1;
          end
        end
      end

      WR_DATA, RD_ADDR, RD_DATA: begin
        tout_d = (busy_rise || busy_fall) ? '0 : tout_q + 1'b1;
        // NACK outranks everything, including a coincident final falling edge
        if (I_ACK_ERR) begin
          en_i2c_d   = 1'b0;
          err_code_d = 2'b01;
          state_d    = ABORT;
        end else if (tout_hit) begin
          en_i2c_d   = 1'b0;
          err_code_d = 2'b10;
          state_d    = ABORT;
        end else begin
          case (state_q)
            WR_DATA: begin
              if (busy_rise) begin
                cnt_rise_d = cnt_rise_q + 1'b1;
                if (cnt_rise_q == len_q) begin
                  en_i2c_d = 1'b0;
                end else begin
                  for (int k = 0; k < MAX_BYTES; k++) begin
                    if (cnt_rise_q == CNT_SZ'(k)) data_wr_d = wbyte[k];
                  end
                end
              end
              if (busy_fall) begin
                if (cnt_fall_q == len_q) begin
                  busy_o_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
                end else begin
                  cnt_fall_d = cnt_fall_q + 1'b1;
                end
              end
            end
            RD_ADDR: begin
              // Raising RW with EN still high makes the master issue a repeated start
              if (busy_rise) rw_d = 1'b1;
              if (busy_fall) begin
                cnt_rise_d = '0;
                cnt_fall_d = '0;
                state_d    = RD_DATA;
              end
            end
            default: begin
              if (busy_rise) begin
                cnt_rise_d = cnt_rise_q + 1'b1;
                if (cnt_rise_q + 1'b1 == len_q) en_i2c_d = 1'b0;
              end
              if (busy_fall) begin
                for (int k = 0; k < MAX_BYTES; k++) begin
                  if (cnt_fall_q == CNT_SZ'(k)) rxd_d[k*DATA_I2C_SZ +: DATA_I2C_SZ] = I_DATA_RD_I2C;
                end
                if (cnt_fall_q + 1'b1 == len_q) begin
                  busy_o_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = IDLE;
                end else begin
                  cnt_fall_d = cnt_fall_q + 1'b1;
                end
              end
            end
          endcase
        end
      end

      ABORT: begin
        tout_d = '0;
        if (!busy_q) begin
          err_d    = 1'b1;
          busy_o_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        en_i2c_d   = 1'b0;
        rw_d       = 1'b0;
        addr_d     = '0;
        data_wr_d  = '0;
        rxd_d      = '0;
        busy_o_d   = 1'b0;
        tout_d     = '0;
        err_d      = 1'b1;
        err_code_d = 2'b11;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      busy_prev_q <= 1'b0;
      len_q       <= '0;
      cnt_rise_q  <= '0;
      cnt_fall_q  <= '0;
      tout_q      <= '0;
      wdata_q     <= '0;
      rxd_q       <= '0;
      en_i2c_q    <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_wr_q   <= '0;
      busy_o_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      en_q        <= I_EN;
      busy_q      <= I_BUSY;
      busy_prev_q <= busy_q;
      len_q       <= len_d;
      cnt_rise_q  <= cnt_rise_d;
      cnt_fall_q  <= cnt_fall_d;
      tout_q      <= tout_d;
      wdata_q     <= wdata_d;
      rxd_q       <= rxd_d;
      en_i2c_q    <= en_i2c_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_wr_q   <= data_wr_d;
      busy_o_q    <= busy_o_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign O_EN_I2C      = en_i2c_q;
  assign O_ADDR_I2C    = addr_q;
  assign O_RW          = rw_q;
  assign O_DATA_WR_I2C = data_wr_q;
  assign O_RXD_BUFF    = rxd_q;
  assign O_BUSY        = busy_o_q;
  assign O_DONE        = done_q;
  assign O_ERR         = err_q;
  assign O_ERR_CODE    = err_code_q;

endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// Directed bench for i2c_burst_ctrl: drives I_BUSY pulses like a byte-level master and
// checks outputs on the falling clock edge against hand-computed values.
module tb_i2c_burst_ctrl;

  localparam int TOUT = 50;

  logic        CLK, RST_n, I_EN, I_RW, I_BUSY, I_ACK_ERR;
  logic [6:0]  I_ADDR_I2C;
  logic [7:0]  I_REG_ADDR, I_DATA_RD_I2C;
  logic [3:0]  I_LEN;
  logic [63:0] I_WDATA;
  logic        O_EN_I2C, O_RW, O_BUSY, O_DONE, O_ERR;
  logic [6:0]  O_ADDR_I2C;
  logic [7:0]  O_DATA_WR_I2C;
  logic [63:0] O_RXD_BUFF;
  logic [1:0]  O_ERR_CODE;

  int n_vec  = 0;
  int n_miss = 0;

  i2c_burst_ctrl #(.ADDR_I2C_SZ(7), .DATA_I2C_SZ(8), .MAX_BYTES(8), .LEN_SZ(4), .TOUT_CYC(TOUT)) dut (
    .CLK(CLK), .RST_n(RST_n), .I_EN(I_EN), .I_ADDR_I2C(I_ADDR_I2C), .I_RW(I_RW),
    .I_REG_ADDR(I_REG_ADDR), .I_LEN(I_LEN), .I_WDATA(I_WDATA), .I_DATA_RD_I2C(I_DATA_RD_I2C),
    .I_BUSY(I_BUSY), .I_ACK_ERR(I_ACK_ERR), .O_EN_I2C(O_EN_I2C), .O_ADDR_I2C(O_ADDR_I2C),
    .O_RW(O_RW), .O_DATA_WR_I2C(O_DATA_WR_I2C), .O_RXD_BUFF(O_RXD_BUFF), .O_BUSY(O_BUSY),
    .O_DONE(O_DONE), .O_ERR(O_ERR), .O_ERR_CODE(O_ERR_CODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_done(output int nd);
    nd = 0;
    repeat (8) begin
      tick(1);
      if (O_DONE) nd++;
    end
  endtask

  task automatic start_cmd(input logic [6:0] a, input logic rw, input logic [7:0] r,
                           input logic [3:0] len, input logic [63:0] wd);
    I_ADDR_I2C = a; I_RW = rw; I_REG_ADDR = r; I_LEN = len; I_WDATA = wd;
    I_EN = 1'b1;
    tick(1);
    I_EN = 1'b0;
    check_eq("en_latency", O_EN_I2C, 0);
    tick(1);
  endtask

  task automatic do_write(input logic [3:0] len, input logic [63:0] wd, input string tag);
    int nd;
    start_cmd(7'h68, 1'b0, 8'h6B, len, wd);
    check_eq({tag, "_en"}, O_EN_I2C, 1);
    check_eq({tag, "_reg"}, O_DATA_WR_I2C, 8'h6B);
    check_eq({tag, "_rw"}, O_RW, 0);
    check_eq({tag, "_busy"}, O_BUSY, 1);
    check_eq({tag, "_errclr"}, {O_ERR, O_ERR_CODE}, 0);
    for (int i = 0; i <= int'(len); i++) begin
      I_BUSY = 1'b1;
      if (i == 0) begin
        // request while busy must be dropped, not queued
        I_ADDR_I2C = 7'h11; I_EN = 1'b1; tick(1); I_EN = 1'b0; tick(2);
      end else begin
        tick(3);
      end
      if (i < int'(len)) begin
        check_eq({tag, "_wbyte"}, O_DATA_WR_I2C, wd[i*8 +: 8]);
        check_eq({tag, "_en_mid"}, O_EN_I2C, 1);
      end else begin
        check_eq({tag, "_en_drop"}, O_EN_I2C, 0);
      end
      I_BUSY = 1'b0;
      tick((i == int'(len)) ? 1 : 3);
    end
    wait_done(nd);
    check_eq({tag, "_done"}, nd, 1);
    check_eq({tag, "_err"}, {O_ERR, O_ERR_CODE}, 0);
    check_eq({tag, "_idle"}, {O_BUSY, O_EN_I2C}, 0);
    check_eq({tag, "_addr"}, O_ADDR_I2C, 7'h68);
    $display("write %s len=%0d done=%0d err=%0d", tag, len, nd, O_ERR);
  endtask

  task automatic do_read(input logic [3:0] len, input logic [63:0] bytes_in,
                         input logic [63:0] exp_rxd, input string tag);
    int nd;
    start_cmd(7'h68, 1'b1, 8'h3B, len, 64'h0);
    check_eq({tag, "_start"}, {O_EN_I2C, O_RW, O_BUSY}, 3'b101);
    check_eq({tag, "_reg"}, O_DATA_WR_I2C, 8'h3B);
    I_BUSY = 1'b1; tick(3);
    check_eq({tag, "_rstart"}, {O_EN_I2C, O_RW}, 2'b11);
    I_BUSY = 1'b0; tick(3);
    for (int i = 0; i < int'(len); i++) begin
      I_BUSY = 1'b1; tick(3);
      check_eq({tag, "_en"}, O_EN_I2C, (i < int'(len) - 1) ? 1 : 0);
      I_BUSY = 1'b0; I_DATA_RD_I2C = bytes_in[i*8 +: 8];
      tick((i == int'(len) - 1) ? 1 : 3);
    end
    wait_done(nd);
    check_eq({tag, "_done"}, nd, 1);
    check_eq({tag, "_rxd"}, O_RXD_BUFF, exp_rxd);
    check_eq({tag, "_err"}, {O_ERR, O_ERR_CODE, O_BUSY}, 0);
    $display("read %s len=%0d rxd=0x%016h done=%0d", tag, len, O_RXD_BUFF, nd);
  endtask

  initial begin
    int nd;
    RST_n = 1'b0; I_EN = 1'b0; I_RW = 1'b0; I_BUSY = 1'b0; I_ACK_ERR = 1'b0;
    I_ADDR_I2C = '0; I_REG_ADDR = '0; I_LEN = '0; I_WDATA = '0; I_DATA_RD_I2C = '0;
    tick(2);
    check_eq("rst_ctl", {O_EN_I2C, O_RW, O_BUSY, O_DONE, O_ERR, O_ERR_CODE}, 0);
    check_eq("rst_data", {O_ADDR_I2C, O_DATA_WR_I2C}, 0);
    check_eq("rst_rxd", O_RXD_BUFF, 0);
    RST_n = 1'b1;
    tick(2);

    do_read(4'd8, 64'hF7F6F5F4F3F2F1F0, 64'hF7F6F5F4F3F2F1F0, "rd8");
    do_write(4'd2, 64'h0100, "wr2");
    check_eq("wr_keeps_rxd", O_RXD_BUFF, 64'hF7F6F5F4F3F2F1F0);
    do_read(4'd6, 64'h0000665544332211, 64'h0000665544332211, "rd6");

    // NACK during the second byte of a write
    start_cmd(7'h68, 1'b0, 8'h6B, 4'd3, 64'h332211);
    I_BUSY = 1'b1; tick(3); I_BUSY = 1'b0; tick(3);
    I_BUSY = 1'b1; tick(1); I_ACK_ERR = 1'b1; tick(1); I_ACK_ERR = 1'b0;
    check_eq("nack_en", O_EN_I2C, 0);
    check_eq("nack_code", O_ERR_CODE, 2'b01);
    tick(2);
    check_eq("nack_wait_busy", {O_BUSY, O_DONE}, 2'b10);
    I_BUSY = 1'b0;
    wait_done(nd);
    check_eq("nack_done", nd, 1);
    check_eq("nack_err", {O_ERR, O_ERR_CODE, O_BUSY}, 4'b1010);
    $display("nack write done=%0d code=%0d", nd, O_ERR_CODE);

    // I_BUSY stuck high until the inactivity timeout fires
    start_cmd(7'h68, 1'b0, 8'h6B, 4'd1, 64'hAB);
    I_BUSY = 1'b1;
    nd = 0;
    repeat (TOUT + 10) begin
      tick(1);
      if (O_DONE) nd++;
    end
    check_eq("tout_early_done", nd, 0);
    check_eq("tout_state", {O_EN_I2C, O_BUSY, O_ERR_CODE}, 4'b0110);
    I_BUSY = 1'b0;
    wait_done(nd);
    check_eq("tout_done", nd, 1);
    check_eq("tout_err", {O_ERR, O_ERR_CODE, O_BUSY}, 4'b1100);
    $display("timeout write done=%0d code=%0d", nd, O_ERR_CODE);
    do_write(4'd1, 64'hC3, "wr_after_tout");

    // illegal lengths 0 and 9
    for (int t = 0; t < 2; t++) begin
      start_cmd(7'h68, 1'b0, 8'h6B, (t == 0) ? 4'd0 : 4'd9, 64'h0);
      check_eq("bad_len_done", O_DONE, 1);
      check_eq("bad_len_err", {O_ERR, O_ERR_CODE, O_EN_I2C, O_BUSY}, 5'b11100);
      wait_done(nd);
      check_eq("bad_len_once", nd, 0);
      check_eq("bad_len_no_en", O_EN_I2C, 0);
      $display("illegal len=%0d code=%0d", I_LEN, O_ERR_CODE);
    end

    // asynchronous reset in the middle of a read
    start_cmd(7'h68, 1'b1, 8'h3B, 4'd4, 64'h0);
    I_BUSY = 1'b1; tick(3); I_BUSY = 1'b0; tick(3);
    I_BUSY = 1'b1; tick(3); I_BUSY = 1'b0; I_DATA_RD_I2C = 8'h77; tick(3);
    check_eq("pre_rst_rxd", O_RXD_BUFF[7:0], 8'h77);
    I_BUSY = 1'b1; tick(1);
    RST_n = 1'b0;
    #1;
    check_eq("arst_ctl", {O_EN_I2C, O_RW, O_BUSY, O_DONE, O_ERR, O_ERR_CODE}, 0);
    check_eq("arst_data", {O_ADDR_I2C, O_DATA_WR_I2C}, 0);
    check_eq("arst_rxd", O_RXD_BUFF, 0);
    I_BUSY = 1'b0;
    tick(1);
    RST_n = 1'b1;
    wait_done(nd);
    check_eq("arst_no_done", nd, 0);
    $display("reset during read, outputs cleared");
    do_read(4'd2, 64'hA55A, 64'hA55A, "rd_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2c_burst_ctrl.md
I2C_BURST_CTRL -- requirements
Module: i2c_burst_ctrl

Interface
REQ-001 Parameter ADDR_I2C_SZ, 7, slave address width on the I2C bus.
REQ-002 Parameter DATA_I2C_SZ, 8, byte width on the I2C bus.
REQ-003 Parameter MAX_BYTES, 8, maximum burst length in bytes (2..15).
REQ-004 Parameter LEN_SZ, 4, width of the burst-length field.
REQ-005 Parameter TOUT_CYC, 500_000, CLK cycles allowed between I_BUSY edges before timeout.
REQ-006 CLK  in  1  clock, all logic on rising edge.
REQ-007 RST_n  in  1  reset, asynchronous, active-low.
REQ-008 I_EN  in  1  command request; sampled only in IDLE.
REQ-009 I_ADDR_I2C  in  ADDR_I2C_SZ  slave address.
REQ-010 I_RW  in  1  0 = burst write, 1 = burst read.
REQ-011 I_REG_ADDR  in  DATA_I2C_SZ  first slave register address.
REQ-012 I_LEN  in  LEN_SZ  number of data bytes, legal range 1..MAX_BYTES.
REQ-013 I_WDATA  in  MAX_BYTES*DATA_I2C_SZ  write bytes; byte k at bits [8k+7:8k].
REQ-014 I_DATA_RD_I2C  in  DATA_I2C_SZ  byte read by the I2C master.
REQ-015 I_BUSY  in  1  I2C master busy; one high pulse per byte.
REQ-016 I_ACK_ERR  in  1  I2C master NACK indication.
REQ-017 O_EN_I2C  out  1  enable to the I2C master.
REQ-018 O_ADDR_I2C  out  ADDR_I2C_SZ  slave address to the master.
REQ-019 O_RW  out  1  RW to the master.
REQ-020 O_DATA_WR_I2C  out  DATA_I2C_SZ  byte to write.
REQ-021 O_RXD_BUFF  out  MAX_BYTES*DATA_I2C_SZ  received bytes; byte k at bits [8k+7:8k].
REQ-022 O_BUSY  out  1  command in progress.
REQ-023 O_DONE  out  1  one-cycle pulse at command end (success or error).
REQ-024 O_ERR  out  1  last command failed; held until the next accepted command.
REQ-025 O_ERR_CODE  out  2  00 none, 01 NACK, 10 timeout, 11 illegal length or illegal state.

Function
REQ-026 I_EN and I_BUSY shall each be registered; I_BUSY edges shall be detected from two registered stages (current and previous).
REQ-027 FSM states shall be IDLE, WR_DATA, RD_ADDR, RD_DATA, ABORT, all registered outputs.
REQ-028 IDLE: on registered I_EN with legal I_LEN, the block shall latch all command inputs, clear O_ERR/O_ERR_CODE, set O_BUSY=1, O_EN_I2C=1, O_ADDR_I2C=I_ADDR_I2C, O_RW=0, O_DATA_WR_I2C=I_REG_ADDR, and go to WR_DATA (I_RW=0) or RD_ADDR (I_RW=1).
REQ-029 I_EN high at edge n shall produce O_EN_I2C high after edge n+1.
REQ-030 IDLE with I_LEN=0 or I_LEN>MAX_BYTES: no I2C activity; O_ERR=1, O_ERR_CODE=11, O_DONE pulse.
REQ-031 WR_DATA: each I_BUSY rising edge shall load the next latched write byte (0,1,..) into O_DATA_WR_I2C; after LEN+1 rising edges O_EN_I2C=0; after LEN+1 falling edges O_BUSY=0, O_DONE pulse, go IDLE.
REQ-032 RD_ADDR: on I_BUSY rising edge O_RW=1 with O_EN_I2C held 1 (repeated start); on falling edge go RD_DATA.
REQ-033 RD_DATA: on falling edge k (k=0..LEN-1) I_DATA_RD_I2C shall be stored in byte k of O_RXD_BUFF; on LEN-th rising edge O_EN_I2C=0; after LEN falling edges O_BUSY=0, O_DONE pulse, go IDLE.
REQ-034 Unused bytes of O_RXD_BUFF (index >= LEN) shall be cleared when a read is accepted; writes shall not modify O_RXD_BUFF.
REQ-035 Same-cycle rising and falling edges cannot occur; simultaneous NACK and final falling edge shall report NACK.
REQ-036 I_ACK_ERR high in any active state: O_EN_I2C=0, O_ERR_CODE=01, go ABORT.
REQ-037 Timeout counter shall reset on every I_BUSY edge and on command accept; reaching TOUT_CYC in an active state: O_EN_I2C=0, O_ERR_CODE=10, go ABORT.
REQ-038 ABORT: wait for registered I_BUSY low, then O_ERR=1, O_BUSY=0, O_DONE pulse, go IDLE.
REQ-039 I_EN while O_BUSY=1 shall be ignored, not queued.
REQ-040 Illegal state encoding: clear all outputs, O_ERR=1, O_ERR_CODE=11, go IDLE.

Reset
REQ-041 RST_n low shall immediately force state IDLE and all outputs, counters and latches to 0, including mid-transaction; no O_DONE is issued.

Verification
REQ-042 Write: addr 0x68, reg 0x6B, LEN=2, data 0x00,0x01 -> O_DATA_WR_I2C sequence 0x6B,0x00,0x01; EN drops after 3rd rise; O_DONE after 3rd fall, O_ERR=0.
REQ-043 Read: addr 0x68, reg 0x3B, LEN=6, bytes 0x11..0x66 -> O_RW 0 then 1 without EN drop; O_RXD_BUFF[47:0]=0x665544332211, upper bytes 0.
REQ-044 NACK on 2nd byte of a write -> EN=0 next cycle; after I_BUSY low O_ERR=1, code 01, one O_DONE.
REQ-045 I_BUSY stuck high TOUT_CYC cycles -> code 10, O_DONE, returns IDLE; next legal command clears O_ERR.
REQ-046 I_LEN=0 and I_LEN=9 -> O_EN_I2C never asserted, code 11, O_DONE pulse each.
REQ-047 RST_n low during RD_DATA -> all outputs 0 at once; subsequent read completes normally.
